// File: rtl/sbox_layer_ctrl.sv
// Iterative 4-bit S-box layer over a 64-bit state, LANES nibbles per cycle.
// Define SBOX_INV_EN to compile in the inverse S-box selected by in_inv.
module sbox_layer_ctrl #(
    parameter int unsigned LANES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Nibble i of each table holds S(i).
    localparam logic [63:0] FWD_TAB = 64'h4D5E_0876_19CA_23FB;

    state_t      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [4:0]  ptr_end;

`ifdef SBOX_INV_EN
    localparam logic [63:0] INV_TAB = 64'h1CE5_046A_98DF_237B;
    logic inv_q, inv_d;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
`ifdef SBOX_INV_EN
        inv_d   = inv_q;
`endif
        ptr_end = {1'b0, ptr_q} + 5'(LANES);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    ptr_d   = '0;
`ifdef SBOX_INV_EN
                    inv_d   = in_inv;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned n = 0; n < 16; n++) begin
                    if (5'(n) >= {1'b0, ptr_q} && 5'(n) < ptr_end) begin
`ifdef SBOX_INV_EN
                        data_d[4*n +: 4] = inv_q ? INV_TAB[4*data_q[4*n +: 4] +: 4]
                                                 : FWD_TAB[4*data_q[4*n +: 4] +: 4];
`else
                        data_d[4*n +: 4] = FWD_TAB[4*data_q[4*n +: 4] +: 4];
`endif
                    end
                end
                // The final window leaves ptr in place; only an accept returns it to 0.
                if (ptr_end == 5'd16) begin
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_end[3:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            ptr_q   <= '0;
`ifdef SBOX_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
`ifdef SBOX_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Self-checking bench for sbox_layer_ctrl at LANES=4, 1 and 16 against a table-driven model.
module tb_sbox_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_inv = 1'b0;
    logic        in_valid_v  [3];
    logic        out_ready_v [3];
    logic        in_ready_v  [3];
    logic        out_valid_v [3];
    logic        busy_v      [3];
    logic [63:0] out_data_v  [3];

    int errors = 0;
    int checks = 0;

    int fwd_tab [16] = '{11, 15, 3, 2, 10, 12, 9, 1, 6, 7, 8, 0, 14, 5, 13, 4};
    int inv_tab [16] = '{11, 7, 3, 2, 15, 13, 8, 9, 10, 6, 4, 0, 5, 14, 12, 1};
    int lanes_of [3] = '{4, 1, 16};

    always #5 clk = ~clk;

    sbox_layer_ctrl #(.LANES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .out_data(out_data_v[0]), .busy(busy_v[0])
    );
    sbox_layer_ctrl #(.LANES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .out_data(out_data_v[1]), .busy(busy_v[1])
    );
    sbox_layer_ctrl #(.LANES(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .out_data(out_data_v[2]), .busy(busy_v[2])
    );

    function automatic logic [63:0] model(input logic [63:0] d, input logic inv);
        logic [63:0] r;
        logic        use_inv;
`ifdef SBOX_INV_EN
        use_inv = inv;
`else
        use_inv = inv & 1'b0;
`endif
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = use_inv ? 4'(inv_tab[d[4*i +: 4]]) : 4'(fwd_tab[d[4*i +: 4]]);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance k; hold>0 keeps out_ready low for 5 DONE cycles.
    task automatic do_txn(input int k, input logic [63:0] d, input logic inv, input int hold);
        logic [63:0] exp;
        int          lat;
        exp = model(d, inv);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready_v[k]), 64'd1);
        in_valid_v[k]  = 1'b1;
        in_data        = d;
        in_inv         = inv;
        out_ready_v[k] = (hold == 0);
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        check("busy_run", 64'(busy_v[k]), 64'd1);
        check("in_ready_run", 64'(in_ready_v[k]), 64'd0);
        in_data = ~d;
        in_inv  = ~inv;
        lat = 0;
        while (out_valid_v[k] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(16 / lanes_of[k]));
        check("out_data", out_data_v[k], exp);
        if (hold > 0) begin
            for (int i = 0; i < 5; i++) begin
                in_valid_v[k] = 1'b1;
                in_data       = {$urandom, $urandom};
                @(negedge clk);
                check("hold_valid", 64'(out_valid_v[k]), 64'd1);
                check("hold_data", out_data_v[k], exp);
                check("hold_in_ready", 64'(in_ready_v[k]), 64'd0);
            end
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b1;
        end
        @(negedge clk);
        check("release_valid", 64'(out_valid_v[k]), 64'd0);
        check("release_in_ready", 64'(in_ready_v[k]), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", 64'(in_ready_v[k]), 64'd1);
            check("rst_out_valid", 64'(out_valid_v[k]), 64'd0);
            check("rst_busy", 64'(busy_v[k]), 64'd0);
            check("rst_out_data", out_data_v[k], 64'h0);
        end
        rst = 1'b0;

        // Known vectors
        do_txn(0, 64'h0123456789ABCDEF, 1'b0, 0);
        check("vector_fwd", model(64'h0123456789ABCDEF, 1'b0), 64'hBF32AC916780E5D4);
`ifdef SBOX_INV_EN
        do_txn(0, 64'hBF32AC916780E5D4, 1'b1, 0);
        check("vector_inv_result", out_data_v[0], 64'h0123456789ABCDEF);
`else
        do_txn(0, 64'h0, 1'b1, 0);
        check("inv_ignored", out_data_v[0], 64'hBBBBBBBBBBBBBBBB);
`endif
        do_txn(1, 64'h0123456789ABCDEF, 1'b0, 0);
        check("lanes1_data", out_data_v[1], 64'hBF32AC916780E5D4);
        do_txn(2, 64'h0123456789ABCDEF, 1'b0, 0);
        check("lanes16_data", out_data_v[2], 64'hBF32AC916780E5D4);

        // Back-pressure in DONE
        do_txn(0, 64'hFEDCBA9876543210, 1'b0, 1);
        do_txn(2, {$urandom, $urandom}, 1'(($urandom_range(0, 1))), 1);

        // Reset during the second RUN cycle
        @(negedge clk);
        in_valid_v[0] = 1'b1;
        in_data       = 64'h0123456789ABCDEF;
        in_inv        = 1'b0;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid_v[0] = 1'b0;
        check("midrun_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("midrun_in_ready", 64'(in_ready_v[0]), 64'd1);
        check("midrun_out_data", out_data_v[0], 64'h0);
        check("midrun_busy", 64'(busy_v[0]), 64'd0);
        do_txn(0, 64'h0123456789ABCDEF, 1'b0, 0);

        // Randomised traffic on every lane configuration
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 12; r++) begin
                do_txn(k, {$urandom, $urandom}, 1'(($urandom_range(0, 1))), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
